shift_sequencer: RTL and testbench

Upstream command generator for the multi-function barrel shifter. It accepts one job (an operand, start amount, step, count and direction) over a valid/ready handshake. It then emits a stream of per-cycle shift commands (data, amount, direction), which drive the barrel shifter's `data_i`, `shift_amount_i` and `shift_direction_i` inputs. It provides rotation sweeps and stepped rotations without software intervention, with backpressure from the consuming stage.

---
 rtl/shift_sequencer.sv | 119 +++++++++++
 tb/tb_shift_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer: turns one accepted job into a stream of barrel-shifter commands.
// Latency: first command valid the cycle after accept; one command per cycle when ready is high.
// Backpressure: cmd_* outputs hold while cmd_ready_i is low; jobs are accepted only in IDLE.
// Optional build macro SHIFT_SEQUENCER_PINGPONG_EN toggles direction on every handshake.
module shift_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int AMT_WIDTH  = 3,
   parameter int CNT_WIDTH  = 4
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  start_valid_i,
   output logic                  start_ready_o,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic [AMT_WIDTH-1:0]  amount_i,
   input  logic [AMT_WIDTH-1:0]  step_i,
   input  logic [CNT_WIDTH-1:0]  count_i,
   input  logic                  direction_i,
   input  logic                  abort_i,
   output logic                  cmd_valid_o,
   input  logic                  cmd_ready_i,
   output logic [DATA_WIDTH-1:0] cmd_data_o,
   output logic [AMT_WIDTH-1:0]  cmd_amount_o,
   output logic                  cmd_direction_o,
   output logic                  cmd_last_o,
   output logic                  busy_o,
   output logic                  done_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t                state;
   state_t                next_state;
   logic [DATA_WIDTH-1:0] data_q;
   logic [AMT_WIDTH-1:0]  amount_q;
   logic [AMT_WIDTH-1:0]  step_q;
   logic                  dir_q;
   logic [CNT_WIDTH-1:0]  remaining;

   logic accept;
   logic handshake;
   logic on_last;

   assign accept    = (state == IDLE) && start_valid_i;
   assign handshake = (state == ISSUE) && cmd_ready_i;
   assign on_last   = (remaining == CNT_WIDTH'(1));

   // State register.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; abort and the final handshake both end the job through FINISH.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (start_valid_i) begin
               next_state = (count_i == '0) ? FINISH : ISSUE;
            end
         end
         ISSUE: begin
            if (abort_i || (cmd_ready_i && on_last)) begin
               next_state = FINISH;
            end
         end
         FINISH: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Job registers: latched at accept, advanced on every command handshake.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         data_q    <= '0;
         amount_q  <= '0;
         step_q    <= '0;
         dir_q     <= 1'b0;
         remaining <= '0;
      end else if (accept) begin
         data_q    <= data_i;
         amount_q  <= amount_i;
         step_q    <= step_i;
         dir_q     <= direction_i;
         remaining <= count_i;
      end else if (handshake) begin
         // Amount wraps naturally at the register width.
         amount_q  <= amount_q + step_q;
         remaining <= remaining - CNT_WIDTH'(1);
`ifdef SHIFT_SEQUENCER_PINGPONG_EN
         dir_q     <= ~dir_q;
`else
         dir_q     <= dir_q;
`endif
      end
   end

   assign start_ready_o   = (state == IDLE);
   assign cmd_valid_o     = (state == ISSUE);
   assign cmd_last_o      = (state == ISSUE) && on_last;
   assign busy_o          = (state != IDLE);
   assign done_o          = (state == FINISH);
   assign cmd_data_o      = data_q;
   assign cmd_amount_o    = amount_q;
   assign cmd_direction_o = dir_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: sweep, backpressure, wrap, zero count,
// ignored start, abort, mid-job reset and direction behaviour.
module tb_shift_sequencer;

   logic       clk_i = 1'b0;
   logic       reset_i;
   logic       start_valid_i;
   logic       start_ready_o;
   logic [7:0] data_i;
   logic [2:0] amount_i;
   logic [2:0] step_i;
   logic [3:0] count_i;
   logic       direction_i;
   logic       abort_i;
   logic       cmd_valid_o;
   logic       cmd_ready_i;
   logic [7:0] cmd_data_o;
   logic [2:0] cmd_amount_o;
   logic       cmd_direction_o;
   logic       cmd_last_o;
   logic       busy_o;
   logic       done_o;

   int n_cmp = 0;
   int n_err = 0;

   shift_sequencer #(.DATA_WIDTH(8), .AMT_WIDTH(3), .CNT_WIDTH(4)) dut (
      .clk_i           (clk_i),
      .reset_i         (reset_i),
      .start_valid_i   (start_valid_i),
      .start_ready_o   (start_ready_o),
      .data_i          (data_i),
      .amount_i        (amount_i),
      .step_i          (step_i),
      .count_i         (count_i),
      .direction_i     (direction_i),
      .abort_i         (abort_i),
      .cmd_valid_o     (cmd_valid_o),
      .cmd_ready_i     (cmd_ready_i),
      .cmd_data_o      (cmd_data_o),
      .cmd_amount_o    (cmd_amount_o),
      .cmd_direction_o (cmd_direction_o),
      .cmd_last_o      (cmd_last_o),
      .busy_o          (busy_o),
      .done_o          (done_o)
   );

   // 10 ns clock.
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic start_job(input logic [7:0] d, input logic [2:0] a, input logic [2:0] s,
                            input logic [3:0] c, input logic dir);
      start_valid_i = 1'b1;
      data_i        = d;
      amount_i      = a;
      step_i        = s;
      count_i       = c;
      direction_i   = dir;
      step();
      start_valid_i = 1'b0;
   endtask

   // Checks presented in the cycle after the final handshake and the cycle after that.
   task automatic chk_finish(input string tag);
      chk({tag, "_done"}, 32'(done_o), 1);
      chk({tag, "_valid_fin"}, 32'(cmd_valid_o), 0);
      chk({tag, "_busy_fin"}, 32'(busy_o), 1);
      step();
      chk({tag, "_done_off"}, 32'(done_o), 0);
      chk({tag, "_ready_idle"}, 32'(start_ready_o), 1);
      chk({tag, "_busy_idle"}, 32'(busy_o), 0);
   endtask

   initial begin
      logic [2:0] wrap_exp [4];
      wrap_exp = '{3'd6, 3'd1, 3'd4, 3'd7};

      reset_i       = 1'b1;
      start_valid_i = 1'b0;
      data_i        = '0;
      amount_i      = '0;
      step_i        = '0;
      count_i       = '0;
      direction_i   = 1'b0;
      abort_i       = 1'b0;
      cmd_ready_i   = 1'b0;
      step();
      step();
      reset_i = 1'b0;
      step();

      // Reset state.
      chk("rst_start_ready", 32'(start_ready_o), 1);
      chk("rst_valid", 32'(cmd_valid_o), 0);
      chk("rst_last", 32'(cmd_last_o), 0);
      chk("rst_busy", 32'(busy_o), 0);
      chk("rst_done", 32'(done_o), 0);
      chk("rst_data", 32'(cmd_data_o), 0);
      chk("rst_amount", 32'(cmd_amount_o), 0);
      chk("rst_dir", 32'(cmd_direction_o), 0);

      // Sweep with no backpressure.
      cmd_ready_i = 1'b1;
      start_job(8'hB4, 3'd0, 3'd1, 4'd8, 1'b0);
      chk("sweep_busy", 32'(busy_o), 1);
      chk("sweep_start_ready", 32'(start_ready_o), 0);
      for (int i = 0; i < 8; i++) begin
         chk("sweep_valid", 32'(cmd_valid_o), 1);
         chk("sweep_amount", 32'(cmd_amount_o), 32'(i));
         chk("sweep_data", 32'(cmd_data_o), 32'hB4);
         chk("sweep_last", 32'(cmd_last_o), (i == 7) ? 1 : 0);
         chk("sweep_dir", 32'(cmd_direction_o), 0);
         chk("sweep_no_done", 32'(done_o), 0);
         step();
      end
      chk_finish("sweep");

      // Backpressure: ready low three cycles before each accept.
      cmd_ready_i = 1'b0;
      start_job(8'h3C, 3'd2, 3'd2, 4'd3, 1'b0);
      for (int i = 0; i < 3; i++) begin
         for (int w = 0; w < 3; w++) begin
            chk("bp_valid_hold", 32'(cmd_valid_o), 1);
            chk("bp_amount_hold", 32'(cmd_amount_o), 32'(2 + 2 * i));
            chk("bp_data_hold", 32'(cmd_data_o), 32'h3C);
            chk("bp_last_hold", 32'(cmd_last_o), (i == 2) ? 1 : 0);
            step();
         end
         cmd_ready_i = 1'b1;
         chk("bp_amount", 32'(cmd_amount_o), 32'(2 + 2 * i));
         step();
         cmd_ready_i = 1'b0;
      end
      chk_finish("bp");

      // Wrap of the amount counter.
      cmd_ready_i = 1'b1;
      start_job(8'h81, 3'd6, 3'd3, 4'd4, 1'b0);
      for (int i = 0; i < 4; i++) begin
         chk("wrap_amount", 32'(cmd_amount_o), 32'(wrap_exp[i]));
         chk("wrap_last", 32'(cmd_last_o), (i == 3) ? 1 : 0);
         step();
      end
      chk_finish("wrap");

      // Zero count: no command, done in the following cycle.
      start_job(8'h11, 3'd1, 3'd1, 4'd0, 1'b0);
      chk("zero_valid", 32'(cmd_valid_o), 0);
      chk_finish("zero");

      // Second start during ISSUE is ignored.
      cmd_ready_i = 1'b0;
      start_job(8'h5A, 3'd0, 3'd1, 4'd3, 1'b0);
      start_valid_i = 1'b1;
      data_i        = 8'hFF;
      amount_i      = 3'd5;
      count_i       = 4'd2;
      step();
      start_valid_i = 1'b0;
      chk("ign_data", 32'(cmd_data_o), 32'h5A);
      chk("ign_amount", 32'(cmd_amount_o), 0);
      cmd_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("ign_seq_amount", 32'(cmd_amount_o), 32'(i));
         step();
      end
      chk_finish("ign");
      step();
      chk("ign_not_queued", 32'(cmd_valid_o), 0);

      // Abort after the third handshake.
      start_job(8'hC3, 3'd0, 3'd1, 4'd8, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("abort_amount", 32'(cmd_amount_o), 32'(i));
         step();
      end
      abort_i     = 1'b1;
      cmd_ready_i = 1'b0;
      step();
      abort_i = 1'b0;
      chk("abort_issued", 32'(cmd_amount_o), 3);
      chk_finish("abort");

      // Reset mid-job: outputs return immediately, no done pulse.
      cmd_ready_i = 1'b1;
      start_job(8'h77, 3'd1, 3'd1, 4'd8, 1'b1);
      step();
      #2;
      reset_i = 1'b1;
      #1;
      chk("mrst_valid", 32'(cmd_valid_o), 0);
      chk("mrst_busy", 32'(busy_o), 0);
      chk("mrst_done", 32'(done_o), 0);
      chk("mrst_start_ready", 32'(start_ready_o), 1);
      chk("mrst_data", 32'(cmd_data_o), 0);
      chk("mrst_amount", 32'(cmd_amount_o), 0);
      chk("mrst_dir", 32'(cmd_direction_o), 0);
      step();
      reset_i = 1'b0;
      step();
      chk("mrst_done_after", 32'(done_o), 0);
      chk("mrst_valid_after", 32'(cmd_valid_o), 0);

      // Direction behaviour across a job starting at 1.
      start_job(8'h0F, 3'd0, 3'd1, 4'd4, 1'b1);
      for (int i = 0; i < 4; i++) begin
`ifdef SHIFT_SEQUENCER_PINGPONG_EN
         chk("pp_dir", 32'(cmd_direction_o), (i % 2 == 0) ? 1 : 0);
`else
         chk("pp_dir", 32'(cmd_direction_o), 1);
`endif
         step();
      end
      chk_finish("pp");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Hard time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
